// File: rtl/alu4_seq.sv
// Multi-cycle sequencer that drives an external alu4 slice one nibble per cycle, LSB first.
// Optional signed-overflow output is enabled by defining ALU4_SEQ_OVERFLOW_EN.
module alu4_seq #(
    parameter int unsigned NIBBLES = 4,
    localparam int unsigned WIDTH = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
`ifdef ALU4_SEQ_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_carry_in,
    output logic [2:0]       alu_select,
    input  logic [3:0]       alu_out,
    input  logic             alu_carry_out
);

    localparam int unsigned IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             beff_msb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    // MSB of the effective second addend, used for signed overflow of arithmetic ops
    always_comb begin
        case (op_q[2:1])
            2'b00:   beff_msb = 1'b0;
            2'b01:   beff_msb = b_q[WIDTH-1];
            2'b10:   beff_msb = ~b_q[WIDTH-1];
            default: beff_msb = 1'b1;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        idx_d        = idx_q;
        carry_d      = carry_q;
        result_d     = result_q;
        cout_d       = cout_q;
        zero_d       = zero_q;
        ovf_d        = ovf_q;
        alu_a        = '0;
        alu_b        = '0;
        alu_carry_in = 1'b0;
        alu_select   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d    = op;
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = '0;
                    carry_d = op[3] ? 1'b0 : op[0];
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a        = a_q[4*idx_q +: 4];
                alu_b        = b_q[4*idx_q +: 4];
                alu_carry_in = carry_q;
                alu_select   = op_q[3] ? {1'b1, op_q[1:0]} : {1'b0, op_q[2:1]};
                result_d[4*idx_q +: 4] = alu_out;
                carry_d = op_q[3] ? 1'b0 : alu_carry_out;
                idx_d   = IW'(idx_q + 1'b1);
                if (idx_q == LAST) begin
                    state_d = DONE;
                    cout_d  = carry_d;
                    zero_d  = (result_d == '0);
                    ovf_d   = !op_q[3] && (a_q[WIDTH-1] == beff_msb)
                              && (result_d[WIDTH-1] != a_q[WIDTH-1]);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;
`ifdef ALU4_SEQ_OVERFLOW_EN
    assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_alu4_seq.sv
// Directed bench for alu4_seq with a behavioural alu4 slice attached to the alu_* ports.
// Overflow checks are compiled in when ALU4_SEQ_OVERFLOW_EN is defined.
module tb_alu4_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        carry_out;
    logic        zero;
`ifdef ALU4_SEQ_OVERFLOW_EN
    logic        overflow;
`endif
    logic [3:0]  alu_a, alu_b, alu_out;
    logic        alu_carry_in, alu_carry_out;
    logic [2:0]  alu_select;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu4_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .carry_out(carry_out), .zero(zero),
`ifdef ALU4_SEQ_OVERFLOW_EN
        .overflow(overflow),
`endif
        .alu_a(alu_a), .alu_b(alu_b), .alu_carry_in(alu_carry_in),
        .alu_select(alu_select), .alu_out(alu_out), .alu_carry_out(alu_carry_out)
    );

    // Reference alu4 slice
    logic [4:0] sum5;
    always_comb begin
        sum5 = '0;
        alu_out = '0;
        alu_carry_out = 1'b0;
        case (alu_select)
            3'd0: sum5 = {1'b0, alu_a} + 5'(alu_carry_in);
            3'd1: sum5 = {1'b0, alu_a} + {1'b0, alu_b} + 5'(alu_carry_in);
            3'd2: sum5 = {1'b0, alu_a} + {1'b0, ~alu_b} + 5'(alu_carry_in);
            3'd3: sum5 = {1'b0, alu_a} + 5'h0F + 5'(alu_carry_in);
            default: sum5 = '0;
        endcase
        if (!alu_select[2]) begin
            alu_out = sum5[3:0];
            alu_carry_out = sum5[4];
        end else begin
            case (alu_select[1:0])
                2'd0: alu_out = alu_a & alu_b;
                2'd1: alu_out = alu_a | alu_b;
                2'd2: alu_out = alu_a ^ alu_b;
                default: alu_out = ~alu_a;
            endcase
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        cout;
        logic        zr;
        logic        ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request; lat returns cycles from accept edge to out_valid (-1 on timeout)
    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        int guard;
        @(negedge clk);
        in_valid = 1'b1; op = o; op_a = a; op_b = b;
        guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("out_valid_after_ack", 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int k;
        logic [15:0] held;

        vecs[0]  = '{4'h2, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'h2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{4'h5, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{4'hE, 16'hA5A5, 16'hFFFF, 16'h5A5A, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'hF, 16'h00F0, 16'h1357, 16'hFF0F, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'h1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'h5, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{4'h2, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'h8, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'h9, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'hC, 16'hF0F0, 16'h0F0F, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'h0, 16'h1234, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'h3, 16'h00FF, 16'h0F00, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'h7, 16'h1234, 16'h0000, 16'h1234, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{4'h4, 16'h0005, 16'h0005, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'hA, 16'h0F0F, 16'h00FF, 16'h0FF0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1;
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result", 32'(result), 32'd0);
        check("reset_alu_sel", 32'(alu_select), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
            check($sformatf("v%0d_carry", i), 32'(carry_out), 32'(vecs[i].cout));
            check($sformatf("v%0d_zero", i), 32'(zero), 32'(vecs[i].zr));
`ifdef ALU4_SEQ_OVERFLOW_EN
            check($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vecs[i].ovf));
`endif
            release_result();
        end

        // Backpressure: result held, second request refused until acknowledged
        issue(4'h2, 16'h1111, 16'h2222, lat);
        check("bp_result", 32'(result), 32'h3333);
        held = result;
        @(negedge clk);
        in_valid = 1'b1; op = 4'h9; op_a = 16'h00F0; op_b = 16'h0F00;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold", 32'(result), 32'(held));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check("bp_idle_out_valid", 32'(out_valid), 32'd0);
        check("bp_idle_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_second_accepted", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        check("bp_second_latency", 32'(k), 32'd4);
        check("bp_second_result", 32'(result), 32'h0FF0);
        release_result();

        // Reset in the middle of RUN, two nibbles processed
        @(negedge clk);
        in_valid = 1'b1; op = 4'h2; op_a = 16'h1234; op_b = 16'h0FFF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_run_alu_a", 32'(alu_a), 32'h2);
        rst = 1'b1;
        #1;
        check("mr_result", 32'(result), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_alu_a", 32'(alu_a), 32'd0);
        check("mr_alu_b", 32'(alu_b), 32'd0);
        check("mr_alu_sel", 32'(alu_select), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) k++;
        end
        check("mr_no_result", 32'(k), 32'd0);
        issue(4'h6, 16'h0000, 16'h0000, lat);
        check("dec_latency", 32'(lat), 32'd4);
        check("dec_result", 32'(result), 32'hFFFF);
        check("dec_carry", 32'(carry_out), 32'd0);
        release_result();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
